// File: rtl/packet_rx.sv
// Receive-side deframer: rebuilds one telemetry packet from ASCII-hex bytes
// and presents its header fields and payload with a one-cycle valid strobe.
//
// state | meaning
// ------+--------------------------------------------------------------
// HUNT  | out of sync; everything is discarded until a 0x0D terminator
// RECV  | in sync; hex nibbles shift in, 0x0D closes the packet
module packet_rx #(
  parameter int NUM_INPUTS          = 2,
  parameter int RESOLUTION          = 4,
  parameter int LAG_AUTO            = 1,
  parameter int LAG_CROSS           = 1,
  parameter int HAS_CROSSCORRELATOR = 0,
  parameter int PAYLOAD_SIZE        = ((HAS_CROSSCORRELATOR != 0 ?
                                        NUM_INPUTS * (NUM_INPUTS - 1) / 2 * (LAG_CROSS * 2 - 1) : 0)
                                       + NUM_INPUTS * LAG_AUTO + NUM_INPUTS) * RESOLUTION,
  parameter int PACKET_SIZE         = 64 + PAYLOAD_SIZE,
  parameter int TOTAL_NIBBLES       = PACKET_SIZE / 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_valid,
  output logic [PAYLOAD_SIZE-1:0] payload,
  output logic [15:0]             tick,
  output logic [3:0]              flags,
  output logic [15:0]             max_lag,
  output logic [11:0]             delay_size,
  output logic [7:0]              num_inputs,
  output logic [7:0]              resolution,
  output logic                    packet_valid,
  output logic                    packet_error,
  output logic                    mismatch
);

  localparam int CW = $clog2(TOTAL_NIBBLES + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(TOTAL_NIBBLES);

  localparam int OFS_TICK  = PAYLOAD_SIZE;
  localparam int OFS_FLAGS = PAYLOAD_SIZE + 16;
  localparam int OFS_MLAG  = PAYLOAD_SIZE + 20;
  localparam int OFS_DELAY = PAYLOAD_SIZE + 36;
  localparam int OFS_NIN   = PAYLOAD_SIZE + 48;
  localparam int OFS_RES   = PAYLOAD_SIZE + 56;

  typedef enum logic {
    S_HUNT = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PACKET_SIZE-1:0] shift_q, shift_d;
  logic [PACKET_SIZE-1:0] hold_q, hold_d;
  logic                   mismatch_q, mismatch_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;

  logic       is_hex;
  logic       is_term;
  logic       is_skip;
  logic [3:0] nibble;
  logic [7:0] rx_nin;
  logic [7:0] rx_res;
  logic       rx_mismatch;

  always_comb begin
    is_hex  = 1'b1;
    nibble  = 4'h0;
    is_term = (rx_byte == 8'h0D);
    is_skip = (rx_byte == 8'h0A) || (rx_byte == 8'h20);
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      nibble = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      nibble = rx_byte[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  // Widen num_inputs before the +1 so 0xFF cannot alias a small input count.
  always_comb begin
    rx_nin      = shift_q[OFS_NIN +: 8];
    rx_res      = shift_q[OFS_RES +: 8];
    rx_mismatch = (({1'b0, rx_nin} + 9'd1) != 9'(NUM_INPUTS)) ||
                  (rx_res != 8'(RESOLUTION));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_HUNT;
      count_q    <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      mismatch_q <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      mismatch_q <= mismatch_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    mismatch_d = mismatch_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    if (rx_valid && !is_skip) begin
      case (state_q)
        S_HUNT: begin
          if (is_term) begin
            state_d = S_RECV;
            count_d = '0;
          end
        end
        S_RECV: begin
          if (is_hex) begin
            if (count_q == FULL_COUNT) begin
              error_d = 1'b1;
              count_d = '0;
              state_d = S_HUNT;
            end else begin
              shift_d = {shift_q[PACKET_SIZE-5:0], nibble};
              count_d = count_q + 1'b1;
            end
          end else if (is_term) begin
            // A terminator always leaves us aligned for the next packet.
            if (count_q == FULL_COUNT) begin
              hold_d     = shift_q;
              mismatch_d = rx_mismatch;
              valid_d    = 1'b1;
            end else if (count_q != '0) begin
              error_d = 1'b1;
            end
            count_d = '0;
          end else begin
            error_d = 1'b1;
            count_d = '0;
            state_d = S_HUNT;
          end
        end
        default: begin
          state_d = S_HUNT;
          count_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    payload      = hold_q[PAYLOAD_SIZE-1:0];
    tick         = hold_q[OFS_TICK  +: 16];
    flags        = hold_q[OFS_FLAGS +: 4];
    max_lag      = hold_q[OFS_MLAG  +: 16];
    delay_size   = hold_q[OFS_DELAY +: 12];
    num_inputs   = hold_q[OFS_NIN   +: 8];
    resolution   = hold_q[OFS_RES   +: 8];
    packet_valid = valid_q;
    packet_error = error_q;
    mismatch     = mismatch_q;
  end

endmodule

// File: tb/tb_packet_rx.sv
// Self-checking bench for packet_rx at default parameters (20-nibble packets),
// with a queue of expected packets consumed whenever packet_valid fires.
module tb_packet_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] payload;
  logic [15:0] tick;
  logic [3:0]  flags;
  logic [15:0] max_lag;
  logic [11:0] delay_size;
  logic [7:0]  num_inputs;
  logic [7:0]  resolution;
  logic        packet_valid;
  logic        packet_error;
  logic        mismatch;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [79:0] exp_q[$];
  logic [79:0] last_pkt = '0;

  packet_rx dut (
    .clk          (clk),
    .reset        (reset),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .payload      (payload),
    .tick         (tick),
    .flags        (flags),
    .max_lag      (max_lag),
    .delay_size   (delay_size),
    .num_inputs   (num_inputs),
    .resolution   (resolution),
    .packet_valid (packet_valid),
    .packet_error (packet_error),
    .mismatch     (mismatch)
  );

  always #5 clk = ~clk;

  function automatic logic exp_mm(input logic [79:0] e);
    return ((int'(e[71:64]) + 1) != 2) || (int'(e[79:72]) != 4);
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [79:0] rnd_pkt();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  // Scoreboard consumer: every packet_valid must match the oldest expected packet.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (packet_valid && packet_error) begin
        errors++;
        $display("FAIL strobe_overlap valid=%0b error=%0b required not both", packet_valid, packet_error);
      end
      if (packet_error) err_cnt++;
      if (packet_valid) begin
        logic [79:0] e;
        valid_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid fields=%h required no strobe",
                   {resolution, num_inputs, delay_size, max_lag, flags, tick, payload});
        end else begin
          e = exp_q.pop_front();
          if ({resolution, num_inputs, delay_size, max_lag, flags, tick, payload} !== e) begin
            errors++;
            $display("FAIL packet_fields got=%h required=%h",
                     {resolution, num_inputs, delay_size, max_lag, flags, tick, payload}, e);
          end
          checks++;
          if (mismatch !== exp_mm(e)) begin
            errors++;
            $display("FAIL mismatch_flag got=%0b required=%0b", mismatch, exp_mm(e));
          end
          last_pkt = e;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [79:0] p, input int n, input bit lower, input bit skips);
    for (int i = 0; i < n; i++) begin
      if (skips && i == 7)  send_byte(8'h20);
      if (skips && i == 13) send_byte(8'h0A);
      send_byte(hexc((i < 20) ? p[79-4*i -: 4] : 4'h0, lower));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    last_pkt = '0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({resolution, num_inputs, delay_size, max_lag, flags, tick, payload} !== 80'h0) begin
      errors++;
      $display("FAIL reset_fields got=%h required=0", {resolution, num_inputs, delay_size, max_lag, flags, tick, payload});
    end
    checks++;
    if ({packet_valid, packet_error, mismatch} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes got=%b required=000", {packet_valid, packet_error, mismatch});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    string s = "0401001000100014A5C3";
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_byte(8'h0D);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
    exp_q.push_back(80'h0401001000100014A5C3);
    send_byte(8'h0D);
    idle(2);
    checks++;
    if (valid_cnt - v0 != 1 || err_cnt - e0 != 0) begin
      errors++;
      $display("FAIL basic_strobes valid=%0d error=%0d required 1 and 0", valid_cnt - v0, err_cnt - e0);
    end
    checks++;
    if (resolution !== 8'h04 || num_inputs !== 8'h01 || delay_size !== 12'h001 || max_lag !== 16'h0001 ||
        flags !== 4'h0 || tick !== 16'h0014 || payload !== 16'hA5C3 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL basic_fields res=%h nin=%h dly=%h lag=%h flg=%h tick=%h pl=%h mm=%b required 04 01 001 0001 0 0014 a5c3 0",
               resolution, num_inputs, delay_size, max_lag, flags, tick, payload, mismatch);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_no_sync();
    string s = "0401001000100014A5C3";
    int v0;
    int e0;
    do_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
    send_byte(8'h0D);
    idle(2);
    checks++;
    if (valid_cnt != v0 || err_cnt != e0 || payload !== 16'h0) begin
      errors++;
      $display("FAIL nosync_discard valid=%0d error=%0d payload=%h required 0 0 0", valid_cnt - v0, err_cnt - e0, payload);
    end
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
    exp_q.push_back(80'h0401001000100014A5C3);
    send_byte(8'h0D);
    idle(2);
    checks++;
    if (valid_cnt - v0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL nosync_second valid=%0d pending=%0d required 1 0", valid_cnt - v0, exp_q.size());
    end
  endtask

  task automatic test_short();
    logic [79:0] p = rnd_pkt();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_pkt(p, 19, 1'b0, 1'b0);
    send_byte(8'h0D);
    idle(2);
    checks++;
    if (err_cnt - e0 != 1 || valid_cnt != v0) begin
      errors++;
      $display("FAIL short_strobes error=%0d valid=%0d required 1 0", err_cnt - e0, valid_cnt - v0);
    end
    checks++;
    if ({resolution, num_inputs, delay_size, max_lag, flags, tick, payload} !== last_pkt) begin
      errors++;
      $display("FAIL short_held got=%h required=%h", {resolution, num_inputs, delay_size, max_lag, flags, tick, payload}, last_pkt);
    end
    p = rnd_pkt();
    exp_q.push_back(p);
    send_pkt(p, 20, 1'b1, 1'b0);
    send_byte(8'h0D);
    idle(2);
    checks++;
    if (valid_cnt - v0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL short_recover valid=%0d pending=%0d required 1 0", valid_cnt - v0, exp_q.size());
    end
  endtask

  task automatic test_overrun();
    logic [79:0] p = rnd_pkt();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_pkt(p, 21, 1'b0, 1'b0);
    idle(2);
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL overrun_error got=%0d required=1", err_cnt - e0);
    end
    send_pkt(p, 20, 1'b0, 1'b0);
    send_byte(8'h0D);
    idle(2);
    checks++;
    if (valid_cnt != v0 || err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL overrun_hunt valid=%0d error=%0d required 0 1", valid_cnt - v0, err_cnt - e0);
    end
    checks++;
    if ({resolution, num_inputs, delay_size, max_lag, flags, tick, payload} !== last_pkt) begin
      errors++;
      $display("FAIL overrun_held got=%h required=%h", {resolution, num_inputs, delay_size, max_lag, flags, tick, payload}, last_pkt);
    end
    p = rnd_pkt();
    exp_q.push_back(p);
    send_pkt(p, 20, 1'b0, 1'b0);
    send_byte(8'h0D);
    idle(2);
    checks++;
    if (valid_cnt - v0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_recover valid=%0d pending=%0d required 1 0", valid_cnt - v0, exp_q.size());
    end
  endtask

  task automatic test_invalid();
    logic [79:0] p = rnd_pkt();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_pkt(p, 10, 1'b0, 1'b0);
    send_byte("G");
    for (int i = 10; i < 20; i++) send_byte(hexc(p[79-4*i -: 4], 1'b0));
    send_byte(8'h0D);
    idle(2);
    checks++;
    if (err_cnt - e0 != 1 || valid_cnt != v0) begin
      errors++;
      $display("FAIL invalid_strobes error=%0d valid=%0d required 1 0", err_cnt - e0, valid_cnt - v0);
    end
    checks++;
    if ({resolution, num_inputs, delay_size, max_lag, flags, tick, payload} !== last_pkt) begin
      errors++;
      $display("FAIL invalid_held got=%h required=%h", {resolution, num_inputs, delay_size, max_lag, flags, tick, payload}, last_pkt);
    end
    exp_q.push_back(p);
    send_pkt(p, 20, 1'b0, 1'b0);
    send_byte(8'h0D);
    idle(2);
    checks++;
    if (valid_cnt - v0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL invalid_recover valid=%0d pending=%0d required 1 0", valid_cnt - v0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [79:0] p1 = rnd_pkt();
    logic [79:0] p2 = rnd_pkt();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    exp_q.push_back(p1);
    exp_q.push_back(p2);
    send_pkt(p1, 20, 1'b0, 1'b1);
    send_byte(8'h0D);
    send_pkt(p2, 20, 1'b1, 1'b1);
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h0D);
    send_byte(8'h0D);
    idle(2);
    checks++;
    if (valid_cnt - v0 != 2 || err_cnt != e0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_strobes valid=%0d error=%0d pending=%0d required 2 0 0",
               valid_cnt - v0, err_cnt - e0, exp_q.size());
    end
  endtask

  task automatic test_mismatch();
    logic [79:0] pk[3];
    logic        mm_req[3];
    pk[0] = {8'h08, 8'h03, 12'h123, 16'h0004, 4'h5, 16'hBEEF, 16'h1234};
    pk[1] = {8'h04, 8'h01, 12'hABC, 16'h0007, 4'hF, 16'h0001, 16'hFFFF};
    pk[2] = {8'h04, 8'hFF, 12'h000, 16'h0000, 4'h0, 16'h0000, 16'h0000};
    mm_req[0] = 1'b1;
    mm_req[1] = 1'b0;
    mm_req[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(pk[k]);
      send_pkt(pk[k], 20, 1'b0, 1'b0);
      send_byte(8'h0D);
      idle(1);
      checks++;
      if (mismatch !== mm_req[k] || exp_q.size() != 0) begin
        errors++;
        $display("FAIL mismatch_case%0d got=%0b pending=%0d required=%0b", k, mismatch, exp_q.size(), mm_req[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [79:0] p = rnd_pkt();
    int v0;
    send_pkt(p, 10, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({resolution, num_inputs, delay_size, max_lag, flags, tick, payload, mismatch, packet_valid, packet_error} !== 83'h0) begin
      errors++;
      $display("FAIL midreset_async got=%h required=0",
               {resolution, num_inputs, delay_size, max_lag, flags, tick, payload, mismatch, packet_valid, packet_error});
    end
    rx_valid = 1'b0;
    last_pkt = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    v0 = valid_cnt;
    for (int i = 10; i < 20; i++) send_byte(hexc(p[79-4*i -: 4], 1'b0));
    send_byte(8'h0D);
    idle(1);
    checks++;
    if (valid_cnt != v0) begin
      errors++;
      $display("FAIL midreset_tail got=%0d required=0", valid_cnt - v0);
    end
    exp_q.push_back(p);
    send_pkt(p, 20, 1'b0, 1'b0);
    send_byte(8'h0D);
    idle(2);
    checks++;
    if (valid_cnt - v0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_recover valid=%0d pending=%0d required 1 0", valid_cnt - v0, exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_no_sync();
    test_short();
    test_overrun();
    test_invalid();
    test_back_to_back();
    test_mismatch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_rx.md
Name: packet_rx

Overview:
- Receive-side deframer for the correlator's telemetry packet stream. It is the other end of the packet transmitter.
- Consumes bytes from a uart_rx instance, reassembles one PACKET_SIZE-bit packet, splits out the 64-bit header fields and the raw payload, and presents them with a one-cycle valid strobe.
- Used in loopback self-test builds and in the aggregator board that collects packets from several correlators.

Parameters:
- NUM_INPUTS, 2, number of correlated inputs in the sending unit.
- RESOLUTION, 4, bits per counter in the payload.
- LAG_AUTO, 1, autocorrelation lags per input.
- LAG_CROSS, 1, crosscorrelation lags (head/tail size is LAG_CROSS*2-1).
- HAS_CROSSCORRELATOR, 0, whether crosscorrelation counters are present in the payload.
- PAYLOAD_SIZE, derived: (HAS_CROSSCORRELATOR ? NUM_INPUTS*(NUM_INPUTS-1)/2*(LAG_CROSS*2-1) : 0) + NUM_INPUTS*LAG_AUTO + NUM_INPUTS, all multiplied by RESOLUTION.
- PACKET_SIZE, derived: 64 + PAYLOAD_SIZE.
- TOTAL_NIBBLES, derived: PACKET_SIZE/4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- rx_byte  in  8  byte from uart_rx, valid only while rx_valid=1.
- rx_valid  in  1  one-cycle byte strobe.
- payload  out  PAYLOAD_SIZE  payload bits [0+:PAYLOAD_SIZE] of the last good packet.
- tick  out  16  header field TICK.
- flags  out  4  {crosscorrelator, led_flags, live_cross, live_auto}.
- max_lag  out  16  header field.
- delay_size  out  12  header field.
- num_inputs  out  8  header field (inputs-1).
- resolution  out  8  header field.
- packet_valid  out  1  one-cycle strobe: a good packet has been latched.
- packet_error  out  1  one-cycle strobe: framing error.
- mismatch  out  1  level: the last good packet's num_inputs+1 or resolution differs from the parameters.

Behaviour:
- Framing: one byte carries one nibble as ASCII hex ('0'-'9', 'A'-'F', 'a'-'f'), most significant nibble first. Byte 0x0D terminates a packet. Bytes 0x0A and 0x20 are ignored in every state. Any other byte is invalid.
- Packet bit layout, LSB to MSB: payload, tick, flags, max_lag, delay_size, num_inputs, resolution. Resolution is therefore the first nibbles on the wire.
- Reset (asynchronous, reset=0):
  - state=HUNT, nibble count=0, shift register=0.
  - All outputs 0.
- FSM (advances only on cycles with rx_valid=1):
  - HUNT: discard everything. On 0x0D go to RECV with count=0. No strobe is issued, because this is resynchronisation.
  - RECV, hex byte with count<TOTAL_NIBBLES: shift reg <= {reg[PACKET_SIZE-5:0], nibble}, count+1.
  - RECV, hex byte with count==TOTAL_NIBBLES: overrun. Pulse packet_error, go to HUNT.
  - RECV, 0x0D with count==TOTAL_NIBBLES: latch all field outputs from the shift register, update mismatch, pulse packet_valid, count=0, stay in RECV.
  - RECV, 0x0D with 0<count<TOTAL_NIBBLES: short packet. Pulse packet_error, count=0, stay in RECV; the terminator itself resyncs.
  - RECV, 0x0D with count=0: empty line, silently ignored.
  - RECV, invalid byte: pulse packet_error, go to HUNT.
- Latency: outputs and packet_valid change on the clk edge that samples the terminator's rx_valid. Strobes are exactly one cycle wide.
- Outputs are driven from a holding register separate from the shift register. They stay stable during reception and after errors, and change only on a good packet.
- packet_valid and packet_error are never asserted in the same cycle.
- Counter width: count is $clog2(TOTAL_NIBBLES+1) bits and must not wrap.
- rx_valid held high on consecutive cycles must be accepted, one byte per cycle.
- Reset asserted mid-packet aborts immediately. The next packet is accepted only after a 0x0D has been seen.

Test Plan:
- Defaults (TOTAL_NIBBLES=20). After reset send 0x0D, then "0401001000100014A5C3", then 0x0D. Required: packet_valid for 1 cycle; resolution=0x04, num_inputs=0x01, delay_size=0x001, max_lag=0x0001, flags=0, tick=0x0014, payload=0xA5C3, mismatch=0.
- Same bytes with no leading 0x0D after reset. Required: first packet discarded with no strobes. Sending the packet again gives packet_valid with the same values.
- Send 19 hex nibbles then 0x0D. Required: packet_error for 1 cycle, outputs unchanged. A following good packet is latched.
- Send 21 hex nibbles. Required: packet_error on the 21st byte; nothing latches until the next 0x0D, and the packet after it latches.
- Inject 'G' at nibble 10. Required: packet_error, HUNT state, previous outputs held.
- Header "0803..." with resolution=8 and num_inputs=3. Required: packet_valid and mismatch=1. Assert reset mid-packet: all outputs return to 0 asynchronously.
